lcd_bus_monitor: RTL and testbench
==================================

// Module: lcd_bus_monitor
// PURPOSE
//  Passive receiver for the HD44780-style 4-bit write bus (LCD_D = {RS, D7..D4}, LCD_E) driven by the LCD init/text sender.
//  Reassembles nibbles into command/data bytes and tracks 8-bit vs 4-bit interface mode through the init sequence.
//  Mirrors the DDRAM address counter and flags timing/protocol violations.
//  Sits beside the sender: on-chip self-check, and the bench scoreboard front-end.
// PARAMETERS
//  MIN_GAP   500  min CLK cycles between consecutive accepted E falling edges (10 us @ 50 MHz)
//  SYNC_STG  2    synchronizer depth on LCD_E/LCD_D (>=2)
// PORTS
//  CLK          in   1  system clock
//  RST          in   1  synchronous active-high reset
//  LCD_D        in   5  [4]=RS, [3:0]=D7..D4, sampled on E fall
//  LCD_E        in   1  enable strobe; data latched on falling edge
//  byte_valid   out  1  1-cycle pulse: byte_rs/byte_data valid
//  byte_rs      out  1  0=command, 1=character data
//  byte_data    out  8  reassembled byte
//  mode4        out  1  1 = 4-bit interface mode active
//  char_we      out  1  1-cycle pulse, character write to DDRAM mirror
//  char_addr    out  7  DDRAM address of that write
//  char_data    out  8  character code
//  ddram_addr   out  7  current mirrored address counter
//  clear_seen   out  1  1-cycle pulse on Clear Display (0x01)
//  timing_err   out  1  sticky: E fall closer than MIN_GAP to previous
//  proto_err    out  1  sticky: RS differs between high and low nibble
// BEHAVIOUR
//  Reset: all pulses 0, byte_data=0, mode4=0, ddram_addr=0, incr=1, nibble phase=HIGH, both err flags 0, gap counter saturated.
//  Input: LCD_E/LCD_D pass SYNC_STG flops; fall = synced E 1->0; D taken from same synced stage. E high/low >=2 CLK guaranteed seen.
//  Latency: byte_valid 1 CLK after detected fall (SYNC_STG+1 CLK after LCD_E first sampled low); char_we/clear_seen same cycle.
//  Mode FSM:
//   MODE8 (reset): each fall -> byte {D[3:0],4'h0}, rs=D[4], pulse. Cmd nibble 0x2 (RS=0) -> MODE4/HIGH, mode4=1.
//   MODE4/HIGH: store nibble+RS, go LOW, no output.
//   MODE4/LOW: byte {hi,lo}, rs=hi RS, pulse, go HIGH; RS mismatch -> proto_err=1, byte still emitted.
//   In MODE4, cmd 0b0011_xxxx (DL=1) -> MODE8 after emission.
//  Decode (emitted byte, RS=0): 0x01 -> ddram_addr=0, incr=1, clear_seen. 0x02/0x03 -> ddram_addr=0.
//   0b000001_I_S -> incr=I. bit7=1 -> ddram_addr=byte[6:0]. Others: no mirror effect.
//  Data (RS=1): char_we, char_addr=ddram_addr, char_data=byte; then addr +/-1 per incr.
//  Address wrap (2-line map): inc 0x27->0x40, 0x67->0x00; dec 0x00->0x67, 0x40->0x27.
//  Gap counter: cleared on each fall, saturates at MIN_GAP; fall with count<MIN_GAP -> timing_err=1 (byte still processed). First fall after reset never errors.
//  RST mid-byte: held high-nibble discarded, FSM to MODE8/HIGH, all state to reset values.
//  Fall on same cycle as RST: ignored.
// TESTING
//  Init 0x3,0x3,0x3,0x2 (MODE8) then 0x2,0xC: bytes 0x30,0x30,0x30,0x20,0x2C; mode4=1 after 4th.
//  MODE4, 0x80|0x45 then data 'A'(0x41): char_we addr=0x45 data=0x41, ddram_addr=0x46.
//  Set addr 0x27, write 'x': char_addr=0x27, ddram_addr=0x40; addr 0x67 + write -> 0x00.
//  Entry 0x04 (I=0) at addr 0x40, write char: char_addr=0x40, ddram_addr=0x27; clear 0x01 -> addr 0, clear_seen.
//  Two falls 100 CLK apart, MIN_GAP=500 -> timing_err=1, stays 1 until RST.
//  High nibble RS=1, low RS=0 -> proto_err=1, byte_rs=1; RST after lone high nibble -> next nibble as MODE8.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// Passive monitor for the HD44780-style 4-bit LCD write bus.
// Reassembles nibbles into bytes and tracks the 8-bit/4-bit interface mode.
// Also mirrors the DDRAM address counter and flags gap and RS-consistency violations.
module lcd_bus_monitor #(
    parameter int unsigned MIN_GAP  = 500,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] LCD_D,
    input  logic       LCD_E,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       mode4,
    output logic       char_we,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    output logic [6:0] ddram_addr,
    output logic       clear_seen,
    output logic       timing_err,
    output logic       proto_err
);

    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);
    localparam int unsigned NIB_W = 5;

    localparam logic [1:0] ST_MODE8 = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;

    // Synchronizer chains for the asynchronous LCD bus.
    logic [SYNC_STG-1:0] e_sync;
    logic [NIB_W-1:0]    d_sync [SYNC_STG];
    logic                e_prev;

    logic             fall_c;
    logic [NIB_W-1:0] nib_c;

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_short_c;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [NIB_W-1:0] hi_q;
    logic [NIB_W-1:0] hi_nxt;

    logic             emit_c;
    logic             emit_rs_c;
    logic [7:0]       emit_byte_c;
    logic             perr_set_c;

    logic [6:0]       addr_nxt;
    logic             incr;
    logic             incr_nxt;
    logic             we_c;
    logic             clr_c;

    // Next DDRAM address on the two-line map (0x00-0x27, 0x40-0x67).
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Shift LCD_E and LCD_D through the synchronizer stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            e_sync <= '0;
            e_prev <= 1'b0;
            for (int i = 0; i < int'(SYNC_STG); i++) begin
                d_sync[i] <= '0;
            end
        end else begin
            e_sync    <= {e_sync[SYNC_STG-2:0], LCD_E};
            e_prev    <= e_sync[SYNC_STG-1];
            d_sync[0] <= LCD_D;
            for (int i = 1; i < int'(SYNC_STG); i++) begin
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    // Falling edge of the synchronized strobe; data taken from the same stage.
    always_comb begin
        fall_c      = e_prev & ~e_sync[SYNC_STG-1];
        nib_c       = d_sync[SYNC_STG-1];
        gap_short_c = fall_c && (gap_cnt < GAP_W'(MIN_GAP));
    end

    // Cycles since the last accepted fall, saturating at MIN_GAP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gap_cnt <= GAP_W'(MIN_GAP);
        end else if (fall_c) begin
            gap_cnt <= '0;
        end else if (gap_cnt < GAP_W'(MIN_GAP)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // Interface mode state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_MODE8;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode FSM: nibble assembly, byte emission and mode switching.
    always_comb begin
        state_nxt   = state;
        hi_nxt      = hi_q;
        emit_c      = 1'b0;
        emit_rs_c   = 1'b0;
        emit_byte_c = 8'h00;
        perr_set_c  = 1'b0;
        case (state)
            ST_MODE8: begin
                if (fall_c) begin
                    emit_c      = 1'b1;
                    emit_rs_c   = nib_c[4];
                    emit_byte_c = {nib_c[3:0], 4'h0};
                    if (nib_c == 5'b0_0010) begin
                        state_nxt = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (fall_c) begin
                    hi_nxt    = nib_c;
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (fall_c) begin
                    emit_c      = 1'b1;
                    emit_rs_c   = hi_q[4];
                    emit_byte_c = {hi_q[3:0], nib_c[3:0]};
                    perr_set_c  = hi_q[4] ^ nib_c[4];
                    if (!hi_q[4] && (hi_q[3:0] == 4'h3)) begin
                        state_nxt = ST_MODE8;
                    end else begin
                        state_nxt = ST_HIGH;
                    end
                end
            end
            default: begin
                state_nxt = ST_MODE8;
            end
        endcase
    end

    // Decode emitted bytes into DDRAM mirror effects.
    always_comb begin
        addr_nxt = ddram_addr;
        incr_nxt = incr;
        we_c     = 1'b0;
        clr_c    = 1'b0;
        if (emit_c) begin
            if (emit_rs_c) begin
                we_c     = 1'b1;
                addr_nxt = addr_step(ddram_addr, incr);
            end else if (emit_byte_c == 8'h01) begin
                addr_nxt = 7'h00;
                incr_nxt = 1'b1;
                clr_c    = 1'b1;
            end else if (emit_byte_c[7:1] == 7'b0000001) begin
                addr_nxt = 7'h00;
            end else if (emit_byte_c[7:2] == 6'b000001) begin
                incr_nxt = emit_byte_c[1];
            end else if (emit_byte_c[7]) begin
                addr_nxt = emit_byte_c[6:0];
            end
        end
    end

    // Registered outputs, address mirror and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
            mode4      <= 1'b0;
            char_we    <= 1'b0;
            char_addr  <= 7'h00;
            char_data  <= 8'h00;
            ddram_addr <= 7'h00;
            incr       <= 1'b1;
            clear_seen <= 1'b0;
            timing_err <= 1'b0;
            proto_err  <= 1'b0;
            hi_q       <= '0;
        end else begin
            byte_valid <= emit_c;
            if (emit_c) begin
                byte_rs   <= emit_rs_c;
                byte_data <= emit_byte_c;
            end
            mode4   <= (state_nxt != ST_MODE8);
            char_we <= we_c;
            if (we_c) begin
                char_addr <= ddram_addr;
                char_data <= emit_byte_c;
            end
            ddram_addr <= addr_nxt;
            incr       <= incr_nxt;
            clear_seen <= clr_c;
            timing_err <= timing_err | gap_short_c;
            proto_err  <= proto_err | perr_set_c;
            hi_q       <= hi_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: a bus driver feeds a reference model,
// a monitor compares every emitted byte against the model's expectation queue.
module tb_lcd_bus_monitor;

    localparam int unsigned MIN_GAP = 500;
    localparam int unsigned SYNC_STG = 2;
    localparam int GAP_OK = 520;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] lcd_d = 5'h00;
    logic       lcd_e = 1'b0;
    logic       byte_valid, byte_rs, mode4, char_we, clear_seen, timing_err, proto_err;
    logic [7:0] byte_data, char_data;
    logic [6:0] char_addr, ddram_addr;

    always #5 clk = ~clk;

    lcd_bus_monitor #(.MIN_GAP(MIN_GAP), .SYNC_STG(SYNC_STG)) dut (
        .CLK(clk), .RST(rst), .LCD_D(lcd_d), .LCD_E(lcd_e),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .mode4(mode4), .char_we(char_we), .char_addr(char_addr),
        .char_data(char_data), .ddram_addr(ddram_addr), .clear_seen(clear_seen),
        .timing_err(timing_err), .proto_err(proto_err)
    );

    typedef struct {
        logic       rs;
        logic [7:0] b;
        logic       m4;
        logic       we;
        logic [6:0] ca;
        logic [7:0] cd;
        logic [6:0] addr;
        logic       clr;
        logic       terr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state.
    bit       m_mode8;
    bit       m_have_hi;
    bit [4:0] m_hi;
    int       m_idx;
    bit       m_incr;
    bit       m_terr;
    bit       m_perr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Linear position 0..79 on the two-line display <-> DDRAM address.
    function automatic int idx2addr(input int i);
        return (i < 40) ? i : (i - 40 + 64);
    endfunction
    function automatic int addr2idx(input int a);
        return (a < 64) ? a : (a - 64 + 40);
    endfunction

    task automatic model_reset();
        m_mode8 = 1; m_have_hi = 0; m_hi = 0; m_idx = 0; m_incr = 1;
        m_terr = 0; m_perr = 0;
    endtask

    task automatic model_emit(input bit rs, input bit [7:0] b);
        exp_t e;
        e.rs = rs; e.b = b; e.we = 0; e.ca = 0; e.cd = 0; e.clr = 0;
        if (rs) begin
            e.we = 1; e.ca = 7'(idx2addr(m_idx)); e.cd = b;
            m_idx = (m_idx + (m_incr ? 1 : 79)) % 80;
        end else if (b == 8'h01) begin
            m_idx = 0; m_incr = 1; e.clr = 1;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_idx = 0;
        end else if (b >= 8'h04 && b <= 8'h07) begin
            m_incr = b[1];
        end else if (b >= 8'h80) begin
            m_idx = addr2idx(int'(b) - 128);
        end
        e.m4 = !m_mode8; e.addr = 7'(idx2addr(m_idx));
        e.terr = m_terr; e.perr = m_perr;
        exp_q.push_back(e);
    endtask

    task automatic model_nibble(input bit [4:0] n, input bit close);
        if (close) m_terr = 1;
        if (m_mode8) begin
            if (n == 5'b0_0010) m_mode8 = 0;
            model_emit(n[4], {n[3:0], 4'h0});
        end else if (!m_have_hi) begin
            m_hi = n; m_have_hi = 1;
        end else begin
            m_have_hi = 0;
            if (m_hi[4] != n[4]) m_perr = 1;
            if (!m_hi[4] && m_hi[3:0] == 4'h3) m_mode8 = 1;
            model_emit(m_hi[4], {m_hi[3:0], n[3:0]});
        end
    endtask

    task automatic send_nibble(input bit [4:0] n, input int gap_after, input bit close);
        @(negedge clk);
        lcd_d = n; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        model_nibble(n, close);
        repeat (gap_after) @(negedge clk);
    endtask

    task automatic send_byte(input bit rs, input bit [7:0] b);
        send_nibble({rs, b[7:4]}, GAP_OK, 1'b0);
        send_nibble({rs, b[3:0]}, GAP_OK, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_byte_data", int'(byte_data), 0);
        check("rst_mode4", int'(mode4), 0);
        check("rst_ddram_addr", int'(ddram_addr), 0);
        check("rst_char_we", int'(char_we), 0);
        check("rst_clear_seen", int'(clear_seen), 0);
        check("rst_timing_err", int'(timing_err), 0);
        check("rst_proto_err", int'(proto_err), 0);
    endtask

    // Monitor: compare every DUT byte against the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got 0x%0h with nothing expected", byte_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("byte_rs", int'(byte_rs), int'(e.rs));
                    check("byte_data", int'(byte_data), int'(e.b));
                    check("mode4", int'(mode4), int'(e.m4));
                    check("char_we", int'(char_we), int'(e.we));
                    if (e.we) begin
                        check("char_addr", int'(char_addr), int'(e.ca));
                        check("char_data", int'(char_data), int'(e.cd));
                    end
                    check("ddram_addr", int'(ddram_addr), int'(e.addr));
                    check("clear_seen", int'(clear_seen), int'(e.clr));
                    check("timing_err", int'(timing_err), int'(e.terr));
                    check("proto_err", int'(proto_err), int'(e.perr));
                end
            end else if (char_we || clear_seen) begin
                n_checks++;
                $display("FAIL stray_pulse: char_we=%0b clear_seen=%0b without byte_valid", char_we, clear_seen);
            end
        end
    end

    initial begin
        int r;
        bit [7:0] b;
        model_reset();
        do_reset();

        // Init sequence in 8-bit mode, then function set in 4-bit mode.
        send_nibble(5'h03, GAP_OK, 1'b0);
        send_nibble(5'h03, GAP_OK, 1'b0);
        send_nibble(5'h03, GAP_OK, 1'b0);
        send_nibble(5'h02, GAP_OK, 1'b0);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b0, 8'h0C);
        send_byte(1'b0, 8'h06);

        // Directed address-mirror cases including both wrap points.
        send_byte(1'b0, 8'hC5);
        send_byte(1'b1, 8'h41);
        send_byte(1'b0, 8'hA7);
        send_byte(1'b1, 8'h78);
        send_byte(1'b0, 8'hE7);
        send_byte(1'b1, 8'h79);
        send_byte(1'b0, 8'h04);
        send_byte(1'b0, 8'hC0);
        send_byte(1'b1, 8'h5A);
        send_byte(1'b0, 8'h80);
        send_byte(1'b1, 8'h5B);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h03);

        // Randomized traffic in 4-bit mode.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                send_byte(1'b1, 8'($urandom_range(8'h20, 8'h7E)));
            end else if (r < 7) begin
                b = 8'(idx2addr($urandom_range(0, 79)));
                send_byte(1'b0, 8'h80 | b);
            end else if (r == 7) begin
                send_byte(1'b0, 8'($urandom_range(4, 7)));
            end else if (r == 8) begin
                send_byte(1'b0, 8'($urandom_range(1, 3)));
            end else begin
                send_byte(1'b0, 8'h0C);
            end
        end

        // Back to 8-bit mode via DL=1, then re-enter 4-bit mode.
        send_byte(1'b0, 8'h38);
        send_nibble(5'h02, GAP_OK, 1'b0);
        send_byte(1'b1, 8'h61);

        // RS differs between nibbles.
        send_nibble(5'b1_0100, GAP_OK, 1'b0);
        send_nibble(5'b0_0010, GAP_OK, 1'b0);
        send_byte(1'b1, 8'h62);

        // Two falls only ~100 cycles apart.
        send_nibble(5'h00, 95, 1'b0);
        send_nibble(5'h0C, GAP_OK, 1'b1);
        check("timing_err_set", int'(timing_err), int'(m_terr));
        send_byte(1'b0, 8'h06);
        check("timing_err_sticky", int'(timing_err), int'(m_terr));

        // Reset after a lone high nibble: next nibble is an 8-bit-mode byte.
        send_nibble(5'h03, GAP_OK, 1'b0);
        do_reset();
        send_nibble(5'h08, GAP_OK, 1'b0);
        send_nibble(5'h02, GAP_OK, 1'b0);
        send_byte(1'b1, 8'h42);

        // Drain remaining expectations with a bounded wait.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
